// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: combinational stall/flush/redirect decode
// plus a MEM-wait watchdog that forces a bus-error flush on timeout.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        except_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err,
  output logic [1:0]  last_cause,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_EXC     = 2'd1,
    CAUSE_ERET    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [5:0]  STALL_MEM   = 6'b011111;
  localparam logic [5:0]  STALL_EX    = 6'b001111;
  localparam logic [5:0]  STALL_ID    = 6'b000111;

  logic [7:0]  r_wait_cnt;
  logic        r_bus_err;
  cause_e      r_last_cause;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_cnt;

  logic        w_timeout;
  cause_e      w_cause;

  // Exception outranks the watchdog, so a coincident exception suppresses it.
  assign w_timeout = !rst && stallreq_mem && !except_valid &&
                     (r_wait_cnt == TIMEOUT_CNT);

  always_comb begin
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    w_cause = CAUSE_NONE;
    if (rst) begin
      stall   = 6'b000000;
    end else if (except_valid) begin
      flush   = 1'b1;
      new_pc  = except_eret ? cp0_epc : EXC_VECTOR;
      w_cause = except_eret ? CAUSE_ERET : CAUSE_EXC;
    end else if (w_timeout) begin
      flush   = 1'b1;
      new_pc  = EXC_VECTOR;
      w_cause = CAUSE_TIMEOUT;
    end else if (stallreq_mem) begin
      stall   = STALL_MEM;
    end else if (stallreq_ex) begin
      stall   = STALL_EX;
    end else if (stallreq_id) begin
      stall   = STALL_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt     <= 8'd0;
      r_bus_err      <= 1'b0;
      r_last_cause   <= CAUSE_NONE;
      r_stall_cycles <= 32'd0;
      r_flush_cnt    <= 16'd0;
    end else begin
      if (flush || !stallreq_mem) begin
        r_wait_cnt <= 8'd0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      r_bus_err <= w_timeout;
      if (flush) begin
        r_last_cause <= w_cause;
        r_flush_cnt  <= r_flush_cnt + 16'd1;
      end
      if ((stall != 6'b000000) && (r_stall_cycles != 32'hFFFFFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign bus_err      = r_bus_err;
  assign last_cause   = r_last_cause;
  assign stall_cycles = r_stall_cycles;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with fixed expectations, then a
// randomized run against a cycle-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] VEC = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_valid, except_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_err;
  logic [1:0]  last_cause;
  logic [31:0] stall_cycles;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.TIMEOUT(TMO), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .except_valid(except_valid), .except_eret(except_eret), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .bus_err(bus_err),
    .last_cause(last_cause), .stall_cycles(stall_cycles), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: length of the current uninterrupted MEM wait,
  // plus the observable registered values.
  int          m_run;
  bit          m_bus_err;
  logic [1:0]  m_cause;
  int          m_flush_cnt;
  longint      m_stall_cycles;

  function automatic void model_comb(output logic [5:0] st, output logic fl,
                                     output logic [31:0] pc, output bit to,
                                     output logic [1:0] cause);
    st = 6'd0; fl = 1'b0; pc = 32'd0; to = 1'b0; cause = 2'd0;
    if (rst) return;
    if (except_valid) begin
      fl = 1'b1;
      pc = except_eret ? cp0_epc : VEC;
      cause = except_eret ? 2'd2 : 2'd1;
    end else if (stallreq_mem && m_run == int'(TMO)) begin
      fl = 1'b1; pc = VEC; to = 1'b1; cause = 2'd3;
    end else if (stallreq_mem) st = 6'b011111;
    else if (stallreq_ex)      st = 6'b001111;
    else if (stallreq_id)      st = 6'b000111;
  endfunction

  always @(posedge clk) begin
    logic [5:0] st; logic fl; logic [31:0] pc; bit to; logic [1:0] cs;
    model_comb(st, fl, pc, to, cs);
    if (rst) begin
      m_run = 0; m_bus_err = 0; m_cause = 0; m_flush_cnt = 0; m_stall_cycles = 0;
    end else begin
      m_bus_err = to;
      if (fl) begin
        m_cause = cs;
        m_flush_cnt = (m_flush_cnt + 1) % 65536;
        m_run = 0;
      end else begin
        m_run = stallreq_mem ? m_run + 1 : 0;
      end
      if (st != 0 && m_stall_cycles < 64'hFFFFFFFF) m_stall_cycles++;
    end
  end

  task automatic drive(input bit r, input bit id, input bit ex, input bit mem,
                       input bit ev, input bit er, input logic [31:0] epc);
    @(negedge clk);
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    except_valid = ev; except_eret = er; cp0_epc = epc;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 32'd0);
    edge_wait();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 1, 32'hDEADBEEF);
    checks++;
    if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_comb: stall=%b flush=%b new_pc=%h, want 000000 0 00000000", stall, flush, new_pc);
    end
    edge_wait();
    edge_wait();
    checks++;
    if (bus_err !== 1'b0 || last_cause !== 2'd0 || stall_cycles !== 32'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: bus_err=%b cause=%0d stall_cycles=%0d flush_cnt=%0d, want all 0",
               bus_err, last_cause, stall_cycles, flush_cnt);
    end
  endtask

  task automatic test_id_ex_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 32'd0);
      checks++;
      if (stall !== 6'b001111 || flush !== 1'b0) begin
        errors++;
        $display("FAIL id_ex_stall cyc%0d: stall=%b flush=%b, want 001111 0", i, stall, flush);
      end
      edge_wait();
    end
    drive(0, 1, 0, 0, 0, 0, 32'd0);
    checks++;
    if (stall !== 6'b000111 || stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL id_only: stall=%b stall_cycles=%0d, want 000111 3", stall, stall_cycles);
    end
    drive(0, 0, 0, 0, 0, 0, 32'd0);
    checks++;
    if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'd0) begin
      errors++;
      $display("FAIL idle: stall=%b flush=%b new_pc=%h, want 0 0 0", stall, flush, new_pc);
    end
  endtask

  task automatic test_exception();
    do_reset();
    drive(0, 1, 1, 1, 0, 0, 32'd0);
    checks++;
    if (stall !== 6'b011111 || flush !== 1'b0) begin
      errors++;
      $display("FAIL mem_stall: stall=%b flush=%b, want 011111 0", stall, flush);
    end
    edge_wait();
    drive(0, 1, 1, 1, 1, 0, 32'h12345678);
    checks++;
    if (stall !== 6'd0 || flush !== 1'b1 || new_pc !== 32'h20) begin
      errors++;
      $display("FAIL exc_flush: stall=%b flush=%b new_pc=%h, want 000000 1 00000020", stall, flush, new_pc);
    end
    edge_wait();
    checks++;
    if (last_cause !== 2'd1 || flush_cnt !== 16'd1 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL exc_after: cause=%0d flush_cnt=%0d bus_err=%b, want 1 1 0", last_cause, flush_cnt, bus_err);
    end
  endtask

  task automatic test_eret();
    drive(0, 0, 0, 0, 1, 1, 32'hBFC00100);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC00100 || stall !== 6'd0) begin
      errors++;
      $display("FAIL eret_flush: flush=%b new_pc=%h stall=%b, want 1 bfc00100 0", flush, new_pc, stall);
    end
    edge_wait();
    drive(0, 0, 0, 0, 0, 1, 32'hBFC00100);
    checks++;
    if (last_cause !== 2'd2 || flush_cnt !== 16'd2 || flush !== 1'b0 || new_pc !== 32'd0) begin
      errors++;
      $display("FAIL eret_after: cause=%0d flush_cnt=%0d flush=%b new_pc=%h, want 2 2 0 0",
               last_cause, flush_cnt, flush, new_pc);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i <= int'(TMO); i++) begin
      drive(0, 0, 0, 1, 0, 0, 32'd0);
      checks++;
      if (i < int'(TMO)) begin
        if (stall !== 6'b011111 || flush !== 1'b0) begin
          errors++;
          $display("FAIL tmo_wait cyc%0d: stall=%b flush=%b, want 011111 0", i, stall, flush);
        end
      end else if (stall !== 6'd0 || flush !== 1'b1 || new_pc !== VEC) begin
        errors++;
        $display("FAIL tmo_flush: stall=%b flush=%b new_pc=%h, want 0 1 00000020", stall, flush, new_pc);
      end
      checks++;
      if (bus_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_buserr_early cyc%0d: bus_err=%b, want 0", i, bus_err);
      end
      edge_wait();
    end
    drive(0, 0, 0, 0, 0, 0, 32'd0);
    checks++;
    if (bus_err !== 1'b1 || last_cause !== 2'd3 || stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL tmo_after: bus_err=%b cause=%0d stall_cycles=%0d, want 1 3 4", bus_err, last_cause, stall_cycles);
    end
    edge_wait();
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_len: bus_err=%b, want 0", bus_err);
    end
  endtask

  task automatic test_timeout_vs_exc();
    do_reset();
    for (int i = 0; i < int'(TMO); i++) begin
      drive(0, 0, 0, 1, 0, 0, 32'd0);
      edge_wait();
    end
    drive(0, 0, 0, 1, 1, 0, 32'd0);
    checks++;
    if (flush !== 1'b1 || new_pc !== VEC) begin
      errors++;
      $display("FAIL tve_flush: flush=%b new_pc=%h, want 1 00000020", flush, new_pc);
    end
    edge_wait();
    drive(0, 0, 0, 1, 0, 0, 32'd0);
    checks++;
    if (bus_err !== 1'b0 || last_cause !== 2'd1 || flush !== 1'b0 || stall !== 6'b011111) begin
      errors++;
      $display("FAIL tve_after: bus_err=%b cause=%0d flush=%b stall=%b, want 0 1 0 011111 (wait cleared)",
               bus_err, last_cause, flush, stall);
    end
    edge_wait();
  endtask

  task automatic test_reset_mid_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0, 32'd0);
      edge_wait();
    end
    drive(1, 0, 0, 1, 0, 0, 32'd0);
    checks++;
    if (stall !== 6'd0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL rmt_in_reset: stall=%b flush=%b, want 0 0", stall, flush);
    end
    edge_wait();
    for (int i = 0; i <= int'(TMO); i++) begin
      drive(0, 0, 0, 1, 0, 0, 32'd0);
      checks++;
      if (flush !== (i == int'(TMO)) || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL rmt_cyc%0d: flush=%b bus_err=%b, want %0d 0", i, flush, bus_err, i == int'(TMO));
      end
      if (i == 0) begin
        checks++;
        if (stall_cycles !== 32'd0) begin
          errors++;
          $display("FAIL rmt_stall_cycles: stall_cycles=%0d, want 0", stall_cycles);
        end
      end
      edge_wait();
    end
    drive(0, 0, 0, 0, 0, 0, 32'd0);
    checks++;
    if (bus_err !== 1'b1 || stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL rmt_after: bus_err=%b stall_cycles=%0d, want 1 4", bus_err, stall_cycles);
    end
  endtask

  task automatic test_flush_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'd0);
      edge_wait();
    end
    checks++;
    if (flush_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL flush_cnt_max: flush_cnt=%h, want ffff", flush_cnt);
    end
    drive(0, 0, 0, 0, 1, 0, 32'd0);
    edge_wait();
    checks++;
    if (flush_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL flush_cnt_wrap: flush_cnt=%h, want 0000", flush_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] e_st; logic e_fl; logic [31:0] e_pc; bit e_to; logic [1:0] e_cs;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 24) == 0), $urandom_range(0, 1), $urandom);
      model_comb(e_st, e_fl, e_pc, e_to, e_cs);
      checks++;
      if (stall !== e_st || flush !== e_fl || new_pc !== e_pc) begin
        errors++;
        $display("FAIL rand_comb cyc%0d: stall=%b flush=%b new_pc=%h, want %b %b %h",
                 i, stall, flush, new_pc, e_st, e_fl, e_pc);
      end
      edge_wait();
      checks++;
      if (bus_err !== m_bus_err || last_cause !== m_cause ||
          flush_cnt !== 16'(m_flush_cnt) || stall_cycles !== 32'(m_stall_cycles)) begin
        errors++;
        $display("FAIL rand_regs cyc%0d: bus_err=%b cause=%0d flush_cnt=%0d stall_cycles=%0d, want %b %0d %0d %0d",
                 i, bus_err, last_cause, flush_cnt, stall_cycles,
                 m_bus_err, m_cause, m_flush_cnt, m_stall_cycles);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    except_valid = 0; except_eret = 0; cp0_epc = 32'd0;
    test_reset();
    test_id_ex_stall();
    test_exception();
    test_eret();
    test_timeout();
    test_timeout_vs_exc();
    test_reset_mid_timeout();
    test_flush_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of consecutive MEM-wait cycles tolerated before a forced bus-error flush (range 1..255).
REQ-002 Parameter EXC_VECTOR, default 32'h00000020, SHALL be the redirect PC for every non-ERET flush.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stallreq_id  in  1  ID-stage hazard (load-use) hold request.
REQ-006 stallreq_ex  in  1  EX-stage multi-cycle (div/madd) hold request.
REQ-007 stallreq_mem  in  1  MEM-stage memory-wait hold request.
REQ-008 except_valid  in  1  MEM stage has a committed exception this cycle.
REQ-009 except_eret  in  1  qualifies except_valid as ERET; ignored when except_valid=0.
REQ-010 cp0_epc  in  32  return address for ERET.
REQ-011 stall  out  6  per-stage hold: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
REQ-012 flush  out  1  clears all pipeline registers this cycle.
REQ-013 new_pc  out  32  redirect PC, valid only while flush=1, else 0.
REQ-014 bus_err  out  1  registered one-cycle pulse after a timeout flush.
REQ-015 last_cause  out  2  registered cause of the most recent flush: 0 none, 1 exception, 2 ERET, 3 timeout.
REQ-016 stall_cycles  out  32  registered count of cycles with stall!=0.
REQ-017 flush_cnt  out  16  registered count of flushes.

Function
REQ-018 stall, flush and new_pc SHALL be combinational from current inputs and the internal wait counter, with zero-cycle latency.
REQ-019 Priority SHALL be: external exception > timeout > MEM > EX > ID > none.
REQ-020 External exception: flush=1, stall=6'b000000, new_pc=cp0_epc if except_eret else EXC_VECTOR.
REQ-021 MEM request, no flush: stall=6'b011111.
REQ-022 EX request, no MEM request, no flush: stall=6'b001111.
REQ-023 ID request only, no flush: stall=6'b000111.
REQ-024 No request, no flush: stall=0, flush=0, new_pc=0.
REQ-025 Internal wait_cnt (8 bit) SHALL increment each cycle stallreq_mem=1 with no flush, and clear to 0 in any cycle with stallreq_mem=0 or flush=1.
REQ-026 Timeout: when stallreq_mem=1, except_valid=0 and wait_cnt==TIMEOUT, the block SHALL drive flush=1, stall=0 and new_pc=EXC_VECTOR that cycle.
REQ-027 bus_err SHALL be 1 for exactly the cycle after a timeout flush, and 0 otherwise.
REQ-028 If except_valid and the timeout condition occur together, the block SHALL apply the exception, leave bus_err=0 and clear wait_cnt.
REQ-029 last_cause SHALL update on the edge ending each flush cycle and hold otherwise.
REQ-030 flush_cnt SHALL increment by 1 per flush cycle and wrap from 16'hFFFF to 0.
REQ-031 stall_cycles SHALL increment per cycle with stall!=0 and saturate at 32'hFFFFFFFF.
REQ-032 Input changes mid-stall SHALL be re-evaluated each cycle; no request is latched.

Reset
REQ-033 With rst=1 at a rising edge, the block SHALL set wait_cnt=0, bus_err=0, last_cause=0, stall_cycles=0 and flush_cnt=0.
REQ-034 While rst=1, the combinational outputs SHALL be forced to stall=0, flush=0 and new_pc=0, and counters SHALL NOT advance.
REQ-035 Reset asserted mid-timeout SHALL discard the partial count, so no bus_err pulse follows.

Verification
REQ-036 stallreq_id=1, stallreq_ex=1 for 3 cycles -> stall=6'b001111 each cycle; stall_cycles=3.
REQ-037 stallreq_mem=1, stallreq_ex=1, stallreq_id=1 -> stall=6'b011111; then except_valid=1, except_eret=0 -> flush=1, stall=0, new_pc=32'h20; next cycle last_cause=1, flush_cnt=1.
REQ-038 except_valid=1, except_eret=1, cp0_epc=32'hBFC00100 -> flush=1, new_pc=32'hBFC00100; next cycle last_cause=2.
REQ-039 TIMEOUT=4, stallreq_mem held high -> stall=6'b011111 for cycles 0-3, flush=1 with new_pc=32'h20 in cycle 4; bus_err=1 in cycle 5 only; last_cause=3.
REQ-040 TIMEOUT=4, stallreq_mem high with except_valid=1 in cycle 4 -> exception flush; bus_err stays 0; last_cause=1.
REQ-041 TIMEOUT=4, stallreq_mem high 3 cycles, rst=1 for 1 cycle, stallreq_mem held high -> first flush occurs 4 cycles after reset releases; stall_cycles restarts from 0.
